nand_gate_exerciser: RTL and testbench
======================================

Name: nand_gate_exerciser

Overview:
- Self-checking stimulus and response block for the two-stage 3-input NAND gate under test.
- Drives all 8 input vectors {a,b,c} into the gate's inputs. After a settle delay it samples the gate's outputs d and e.
- Compares the samples against the golden model d=~(a&b), e=~(c&d).
- Reports pass/fail, a saturating error count and the first failing vector. Sits on the lab board between the gate and the LED/switch wrapper.

Parameters:
- SETTLE_CYCLES, 2, clocks a vector is held before sampling; legal range ≥1.
- PASSES, 1, number of full 8-vector sweeps per run; legal range ≥1.
- CNT_W, 8, width of the error counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  run request; sampled only in IDLE.
- a_o  output  1  drive to DUT input a (vec[2]).
- b_o  output  1  drive to DUT input b (vec[1]).
- c_o  output  1  drive to DUT input c (vec[0]).
- d_i  input  1  DUT output d.
- e_i  input  1  DUT output e.
- busy  output  1  high from the start-sampling edge until DONE exits.
- done  output  1  one-cycle completion pulse.
- pass  output  1  1 when the last run had err_cnt==0; held until the next start.
- err_cnt  output  CNT_W  number of mismatched checks, saturating.
- fail_vec  output  3  first failing {a,b,c}; valid when fail_valid=1.
- fail_valid  output  1  at least one mismatch recorded this run.

Behaviour:
- Reset: all outputs 0, state IDLE, vec=0, pass_cnt=0, settle counter=0.
- Reset mid-run aborts the run immediately. No done pulse. Results are cleared.
- FSM states are IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - a_o/b_o/c_o=0.
  - On start=1: vec<=0, pass_cnt<=0, err_cnt<=0, fail_valid<=0, fail_vec<=0, pass<=0, settle<=SETTLE_CYCLES-1, busy<=1, go to SETTLE.
- SETTLE:
  - a_o/b_o/c_o = vec.
  - If settle==0, go to CHECK; else decrement settle.
- CHECK:
  - Compute exp_d=~(a&b) and exp_e=~(c&exp_d). exp_e chains from exp_d, not from d_i.
  - A mismatch is (d_i!=exp_d)|(e_i!=exp_e).
  - On mismatch: err_cnt increments, saturating. If fail_valid==0, set fail_vec<=vec and fail_valid<=1.
  - If vec==7 and pass_cnt==PASSES-1, go to DONE.
  - Else if vec==7: vec<=0, pass_cnt++, reload settle, go to SETTLE.
  - Else: vec++, reload settle, go to SETTLE.
- DONE:
  - done=1 for exactly this cycle, and busy stays 1 for this cycle. pass<=(err_cnt==0) is registered here.
  - Go to IDLE with busy<=0.
- Latency:
  - Each vector occupies SETTLE_CYCLES+1 clocks.
  - done is high in the cycle after edge N=8·PASSES·(SETTLE_CYCLES+1), counted from the edge that sampled start. Defaults give N=24.
- start while busy (SETTLE/CHECK/DONE) is ignored.
- A start that is held continuously re-triggers on the first IDLE cycle after DONE.
- err_cnt, fail_vec, fail_valid and pass stay stable after done until the next accepted start.
- Sampling: d_i/e_i are sampled on the CHECK edge only. Changes on them during SETTLE have no effect.

Optional Feature:
- Macro: NAND_EXERCISER_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK records err_cnt=1 and fail_vec, then goes directly to DONE. No further vectors are driven.
- Undefined: every vector of every pass is checked, as described in Behaviour.

Test Plan:
- Correct gate model, defaults, start pulse at edge 0 -> done high after edge 24; pass=1, err_cnt=0, fail_valid=0. a/b/c step through 000..111, each held 3 clocks.
- e stuck-at-0, defaults -> err_cnt=5 (vectors 000,010,100,110,111), fail_vec=000, fail_valid=1, pass=0.
- Same stuck fault with PASSES=3 -> done after edge 72; err_cnt=15. Fault with CNT_W=2 -> err_cnt saturates at 3.
- start re-pulsed at edges 5 and 12 -> ignored; done pulses once. Reset asserted at edge 10 -> busy=0, a/b/c=0, no done. A new start then runs a full 24-edge sweep.
- NAND_EXERCISER_STOP_ON_FAIL_EN defined, e stuck-at-0 -> done after edge 3; err_cnt=1, fail_vec=000, a/b/c never reach 001.
- d stuck-at-1 (so e is computed from the faulty d in the DUT) -> mismatches at 110 (d) and 111 (d and e); err_cnt=2, fail_vec=110.

Source files
------------

// File: rtl/nand_gate_exerciser.sv
// Stimulus/response checker for the two-stage 3-input NAND gate on the lab board.
// Optional build macro NAND_EXERCISER_STOP_ON_FAIL_EN ends the run at the first mismatch.
module nand_gate_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  input  logic             d_i,
  input  logic             e_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       fail_vec,
  output logic             fail_valid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [SW-1:0]    SETTLE_RELOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]    SETTLE_ONE    = SW'(1);
  localparam logic [PW-1:0]    LAST_PASS     = PW'(PASSES - 1);
  localparam logic [PW-1:0]    PASS_ONE      = PW'(1);
  localparam logic [CNT_W-1:0] ERR_ONE       = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [PW-1:0]    pass_cnt_q, pass_cnt_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [2:0]       fail_vec_q, fail_vec_d;
  logic             fail_valid_q, fail_valid_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;

  logic exp_d, exp_e, mismatch, stop_now, last_vec, last_pass;

  // Golden model: the second stage chains from the expected d, so a bad d
  // cannot mask itself by also corrupting the expected e.
  assign exp_d     = ~(vec_q[2] & vec_q[1]);
  assign exp_e     = ~(vec_q[0] & exp_d);
  assign mismatch  = (d_i != exp_d) | (e_i != exp_e);
  assign last_vec  = (vec_q == 3'd7);
  assign last_pass = (pass_cnt_q == LAST_PASS);

`ifdef NAND_EXERCISER_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    pass_cnt_d   = pass_cnt_q;
    settle_d     = settle_q;
    err_cnt_d    = err_cnt_q;
    fail_vec_d   = fail_vec_q;
    fail_valid_d = fail_valid_q;
    pass_d       = pass_q;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d        = 3'd0;
          pass_cnt_d   = '0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 3'd0;
          pass_d       = 1'b0;
          settle_d     = SETTLE_RELOAD;
          busy_d       = 1'b1;
          state_d      = SETTLE;
        end
      end

      SETTLE: begin
        if (settle_q == '0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - SETTLE_ONE;
        end
      end

      CHECK: begin
        if (mismatch) begin
          if (!(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
          end
          if (!fail_valid_q) begin
            fail_vec_d   = vec_q;
            fail_valid_d = 1'b1;
          end
        end
        if (stop_now || (last_vec && last_pass)) begin
          state_d = DONE;
        end else if (last_vec) begin
          vec_d      = 3'd0;
          pass_cnt_d = pass_cnt_q + PASS_ONE;
          settle_d   = SETTLE_RELOAD;
          state_d    = SETTLE;
        end else begin
          vec_d    = vec_q + 3'd1;
          settle_d = SETTLE_RELOAD;
          state_d  = SETTLE;
        end
      end

      DONE: begin
        pass_d  = (err_cnt_q == '0);
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= 3'd0;
      pass_cnt_q   <= '0;
      settle_q     <= '0;
      err_cnt_q    <= '0;
      fail_vec_q   <= 3'd0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      pass_cnt_q   <= pass_cnt_d;
      settle_q     <= settle_d;
      err_cnt_q    <= err_cnt_d;
      fail_vec_q   <= fail_vec_d;
      fail_valid_q <= fail_valid_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
    end
  end

  // The gate is only driven while a vector is being exercised.
  assign {a_o, b_o, c_o} = ((state_q == SETTLE) || (state_q == CHECK)) ? vec_q : 3'd0;

  assign busy       = busy_q;
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_nand_gate_exerciser.sv
// Directed bench for nand_gate_exerciser: three instances (defaults, PASSES=3, CNT_W=2)
// each exercising a behavioural NAND gate with an injectable stuck-at fault.
module tb_nand_gate_exerciser;

`ifdef NAND_EXERCISER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk;
  logic rst;
  logic start;
  int   fault;
  int   sel;
  int   checks;
  int   errors;

  logic a0, b0, c0, d0, e0, busy0, done0, pass0, fval0;
  logic [7:0] err0;
  logic [2:0] fv0;
  logic a1, b1, c1, d1, e1, busy1, done1, pass1, fval1;
  logic [7:0] err1;
  logic [2:0] fv1;
  logic a2, b2, c2, d2, e2, busy2, done2, pass2, fval2;
  logic [1:0] err2;
  logic [2:0] fv2;

  logic       busy_s, done_s, pass_s, fval_s;
  logic [7:0] err_s;
  logic [2:0] fv_s, abc_s;

  nand_gate_exerciser u_dut0 (
    .clk(clk), .rst(rst), .start(start), .a_o(a0), .b_o(b0), .c_o(c0),
    .d_i(d0), .e_i(e0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_vec(fv0), .fail_valid(fval0)
  );

  nand_gate_exerciser #(.PASSES(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .a_o(a1), .b_o(b1), .c_o(c1),
    .d_i(d1), .e_i(e1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fv1), .fail_valid(fval1)
  );

  nand_gate_exerciser #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .a_o(a2), .b_o(b2), .c_o(c2),
    .d_i(d2), .e_i(e2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .fail_vec(fv2), .fail_valid(fval2)
  );

  // fault: 0 = healthy, 1 = e stuck-at-0, 2 = d stuck-at-1 (e sees the bad d)
  function automatic logic [1:0] gate(input int f, input logic a, input logic b, input logic c);
    logic d, e;
    d = ~(a & b);
    if (f == 2) d = 1'b1;
    e = ~(c & d);
    if (f == 1) e = 1'b0;
    return {d, e};
  endfunction

  always_comb begin
    {d0, e0} = gate(fault, a0, b0, c0);
    {d1, e1} = gate(fault, a1, b1, c1);
    {d2, e2} = gate(fault, a2, b2, c2);
  end

  always_comb begin
    busy_s = busy0; done_s = done0; pass_s = pass0; fval_s = fval0;
    err_s = err0; fv_s = fv0; abc_s = {a0, b0, c0};
    case (sel)
      1: begin
        busy_s = busy1; done_s = done1; pass_s = pass1; fval_s = fval1;
        err_s = err1; fv_s = fv1; abc_s = {a1, b1, c1};
      end
      2: begin
        busy_s = busy2; done_s = done2; pass_s = pass2; fval_s = fval2;
        err_s = {6'd0, err2}; fv_s = fv2; abc_s = {a2, b2, c2};
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Starts a run and returns the edge index (counted from the start-sampling
  // edge) after which done was first seen; checks the driven vector meanwhile.
  task automatic run_sweep(input int limit, input int p1, input int p2,
                           output int cycles, output int max_vec, output bit seq_ok);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cycles  = 0;
    max_vec = 0;
    seq_ok  = 1'b1;
    while (!done_s && cycles < limit) begin
      if (abc_s !== 3'((cycles / 3) % 8)) seq_ok = 1'b0;
      if (int'(abc_s) > max_vec) max_vec = int'(abc_s);
      start = (cycles == p1 || cycles == p2);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string name, input int cycles, input int exp_cycles,
                           input int exp_err, input logic [2:0] exp_fv,
                           input logic exp_fval, input logic exp_pass);
    checks++;
    if (cycles !== exp_cycles) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d edges, expected %0d", name, cycles, exp_cycles);
    end
    checks++;
    if (busy_s !== 1'b1 || done_s !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s done_cycle: busy=%b done=%b, expected 1 1", name, busy_s, done_s);
    end
    checks++;
    if (err_s !== 8'(exp_err)) begin
      errors++;
      $display("[TB] FAIL %s err_cnt: got %0d, expected %0d", name, err_s, exp_err);
    end
    checks++;
    if (fval_s !== exp_fval || (exp_fval && fv_s !== exp_fv)) begin
      errors++;
      $display("[TB] FAIL %s fail_vec: got valid=%b vec=%b, expected valid=%b vec=%b",
               name, fval_s, fv_s, exp_fval, exp_fv);
    end
    @(negedge clk);
    checks++;
    if (done_s !== 1'b0 || busy_s !== 1'b0 || pass_s !== exp_pass) begin
      errors++;
      $display("[TB] FAIL %s after_done: done=%b busy=%b pass=%b, expected 0 0 %b",
               name, done_s, busy_s, pass_s, exp_pass);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err_s !== 8'(exp_err) || pass_s !== exp_pass || done_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s hold: err=%0d pass=%b done=%b, expected %0d %b 0",
               name, err_s, pass_s, done_s, exp_err, exp_pass);
    end
  endtask

  task automatic test_reset();
    sel   = 0;
    fault = 0;
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({a0, b0, c0, busy0, done0, pass0, fval0} !== 7'd0 || err0 !== 8'd0 || fv0 !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: abc=%b busy=%b done=%b pass=%b err=%0d fv=%b fval=%b, expected all 0",
               {a0, b0, c0}, busy0, done0, pass0, err0, fv0, fval0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_sweep();
    int cyc, mx;
    bit ok;
    apply_reset();
    sel = 0; fault = 0;
    run_sweep(200, -1, -1, cyc, mx, ok);
    checks++;
    if (ok !== 1'b1 || mx !== 7) begin
      errors++;
      $display("[TB] FAIL good_vectors: in_order=%b max=%0d, expected 1 7", ok, mx);
    end
    check_run("good", cyc, 24, 0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic test_stuck_e();
    int cyc, mx;
    bit ok;
    apply_reset();
    sel = 0; fault = 1;
    run_sweep(200, -1, -1, cyc, mx, ok);
    checks++;
    if (ok !== 1'b1 || mx !== (STOP ? 0 : 7)) begin
      errors++;
      $display("[TB] FAIL stuck_e_vectors: in_order=%b max=%0d, expected 1 %0d", ok, mx, STOP ? 0 : 7);
    end
    check_run("stuck_e", cyc, STOP ? 3 : 24, STOP ? 1 : 5, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_passes3();
    int cyc, mx;
    bit ok;
    apply_reset();
    sel = 1; fault = 1;
    run_sweep(400, -1, -1, cyc, mx, ok);
    check_run("passes3", cyc, STOP ? 3 : 72, STOP ? 1 : 15, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_saturate();
    int cyc, mx;
    bit ok;
    apply_reset();
    sel = 2; fault = 1;
    run_sweep(200, -1, -1, cyc, mx, ok);
    check_run("cnt_w2", cyc, STOP ? 3 : 24, STOP ? 1 : 3, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_stuck_d();
    int cyc, mx;
    bit ok;
    apply_reset();
    sel = 0; fault = 2;
    run_sweep(200, -1, -1, cyc, mx, ok);
    check_run("stuck_d", cyc, STOP ? 21 : 24, STOP ? 1 : 2, 3'd6, 1'b1, 1'b0);
  endtask

  task automatic test_ignored_start();
    int cyc, mx, extra;
    bit ok;
    apply_reset();
    sel = 0; fault = 0;
    run_sweep(200, 4, 11, cyc, mx, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignored_start_vectors: in_order=%b, expected 1", ok);
    end
    check_run("ignored_start", cyc, 24, 0, 3'd0, 1'b0, 1'b1);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_s) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("[TB] FAIL ignored_start_second_done: got %0d extra pulses, expected 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int cyc, mx, seen;
    bit ok;
    apply_reset();
    sel = 0; fault = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_s !== 1'b0 || abc_s !== 3'd0 || done_s !== 1'b0 || err_s !== 8'd0 || fval_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_abort: busy=%b abc=%b done=%b err=%0d fval=%b, expected 0 000 0 0 0",
               busy_s, abc_s, done_s, err_s, fval_s);
    end
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_s) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("[TB] FAIL reset_abort_no_done: got %0d done pulses, expected 0", seen);
    end
    fault = 0;
    run_sweep(200, -1, -1, cyc, mx, ok);
    check_run("after_abort", cyc, 24, 0, 3'd0, 1'b0, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    fault  = 0;
    sel    = 0;
    test_reset();
    test_good_sweep();
    test_stuck_e();
    test_passes3();
    test_saturate();
    test_stuck_d();
    test_ignored_start();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
